// File: rtl/gcd_sched.sv
// gcd_sched: two-port round-robin scheduler sharing a single subtractive gcd unit
// Optional feature: define GCD_SCHED_ZERO_BYPASS_EN to finish zero-operand jobs without the gcd unit.

module gcd_unit #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ld,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] q,
    output logic         rdy
);
    logic [W-1:0] x, y;

    // Euclid by subtraction: keep x >= y by swapping, finish when y reaches zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x   <= '0;
            y   <= '0;
            rdy <= 1'b1;
        end else if (ld) begin
            x   <= a;
            y   <= b;
            rdy <= 1'b0;
        end else if (!rdy) begin
            if (y == '0)
                rdy <= 1'b1;
            else if (x >= y)
                x <= x - y;
            else begin
                x <= y;
                y <= x;
            end
        end
    end

    assign q = x;
endmodule

module gcd_sched #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         req0,
    input  logic         req1,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         done0,
    output logic         done1,
    output logic [W-1:0] q0,
    output logic [W-1:0] q1,
    output logic         busy,
    output logic [15:0]  jobs
);
    typedef enum logic [1:0] {IDLE, LOAD, BUSY, DONE} state_t;

    state_t       state, state_nx;
    logic         any, sel, byp, gnt, take, ld, first, port, last, gcd_reset, gcd_rdy;
    logic [W-1:0] la, lb, gcd_q;

    assign any       = req0 | req1;
    assign sel       = (req0 & req1) ? ~last : req1;
    assign gnt       = gnt0 | gnt1;
    assign ld        = state == LOAD;
    assign take      = state == BUSY && !first && gcd_rdy;
    assign busy      = state != IDLE;
    assign gcd_reset = ~reset_n;

`ifdef GCD_SCHED_ZERO_BYPASS_EN
    assign byp = sel ? (a1 == '0 || b1 == '0) : (a0 == '0 || b0 == '0);
`else
    assign byp = 1'b0;
`endif

    gcd_unit #(.W(W)) u_gcd (
        .clk   (clk),
        .reset (gcd_reset),
        .ld    (ld),
        .a     (la),
        .b     (lb),
        .q     (gcd_q),
        .rdy   (gcd_rdy)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next state and grant; grants are held off while reset is asserted
    always_comb begin
        state_nx = state;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        case (state)
            IDLE: if (any && reset_n) begin
                state_nx = byp ? DONE : LOAD;
                gnt0     = !sel;
                gnt1     = sel;
            end
            LOAD:    state_nx = BUSY;
            BUSY:    if (take) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand latch, result capture, done pulses, job count and round-robin pointer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            la    <= '0;
            lb    <= '0;
            port  <= 1'b0;
            last  <= 1'b1;
            first <= 1'b0;
            q0    <= '0;
            q1    <= '0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            jobs  <= '0;
        end else begin
            first <= state == LOAD;
            done0 <= state == DONE && !port;
            done1 <= state == DONE && port;
            if (gnt) begin
                la   <= sel ? a1 : a0;
                lb   <= sel ? b1 : b0;
                port <= sel;
            end
            if (gnt && byp) begin
                if (sel)
                    q1 <= a1 | b1;
                else
                    q0 <= a0 | b0;
            end
            if (take) begin
                if (port)
                    q1 <= gcd_q;
                else
                    q0 <= gcd_q;
            end
            if (state == DONE) begin
                jobs <= jobs + 16'd1;
                last <= port;
            end
        end
    end
endmodule

// File: tb/tb_gcd_sched.sv
// tb_gcd_sched: randomized and directed bench for gcd_sched against a queue-based reference model
// Honors GCD_SCHED_ZERO_BYPASS_EN when it is defined for the design build.

module tb_gcd_sched;
    logic       clk, reset_n, req0, req1;
    logic [7:0] a0, b0, a1, b1;
    logic       gnt0, gnt1, done0, done1, busy;
    logic [7:0] q0, q1;
    logic [15:0] jobs;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ndone = 0;
    int g0cnt = 0;
    int ld_cnt = 0;
    int gnt_cyc = 0;
    int done_cyc = 0;
    logic [15:0] mjobs = 0;
    logic [7:0] mq0 = 0, mq1 = 0;
    logic [7:0] e0[$], e1[$];
    int gq[$];

    gcd_sched #(.W(8)) dut (
        .clk(clk), .reset_n(reset_n), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .q0(q0), .q1(q1), .busy(busy), .jobs(jobs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_gcd(input int x, input int y);
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x[7:0];
    endfunction

    // Reference model: expected results queue per port, job count, grant order and invariants
    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            e0.delete();
            e1.delete();
            gq.delete();
            mjobs = 0;
            mq0 = 0;
            mq1 = 0;
        end else begin
            if (dut.ld) ld_cnt++;
            if (gnt0 | gnt1) begin
                check("gnt_onehot", {31'b0, gnt0 & gnt1}, 0);
                check("gnt_only_idle", {31'b0, busy}, 0);
                gnt_cyc = cyc;
                if (gnt0) begin e0.push_back(ref_gcd(a0, b0)); gq.push_back(0); g0cnt++; end
                if (gnt1) begin e1.push_back(ref_gcd(a1, b1)); gq.push_back(1); end
            end
            if (done0 | done1) begin
                check("done_onehot", {31'b0, done0 & done1}, 0);
                ndone++;
                done_cyc = cyc;
                mjobs++;
                check("jobs", {16'b0, jobs}, {16'b0, mjobs});
            end
            if (done0) begin
                check("done0_expected", {31'b0, e0.size() != 0}, 1);
                if (e0.size() != 0) mq0 = e0.pop_front();
                check("q0", {24'b0, q0}, {24'b0, mq0});
                check("q1_untouched", {24'b0, q1}, {24'b0, mq1});
            end
            if (done1) begin
                check("done1_expected", {31'b0, e1.size() != 0}, 1);
                if (e1.size() != 0) mq1 = e1.pop_front();
                check("q1", {24'b0, q1}, {24'b0, mq1});
                check("q0_untouched", {24'b0, q0}, {24'b0, mq0});
            end
        end
    end

    task automatic set_req(input bit p, input logic r, input logic [7:0] a, input logic [7:0] b);
        if (p) begin req1 = r; a1 = a; b1 = b; end
        else begin req0 = r; a0 = a; b0 = b; end
    endtask

    task automatic wait_gnt(input bit p);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(p ? gnt1 : gnt0) && k < 3000);
        check(p ? "gnt1_timeout" : "gnt0_timeout", {31'b0, p ? gnt1 : gnt0}, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit p, input logic [7:0] a, input logic [7:0] b);
        set_req(p, 1'b1, a, b);
        wait_gnt(p);
        set_req(p, 1'b0, a, b);
    endtask

    task automatic drive(input bit p, input int n, input bit hold);
        for (int i = 0; i < n; i++) begin
            set_req(p, 1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            wait_gnt(p);
            if (!hold || i == n - 1) begin
                set_req(p, 1'b0, 8'd0, 8'd0);
                repeat ($urandom_range(0, 20)) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_done(input int target);
        int k = 0;
        while (ndone < target && k < 8000) begin
            @(posedge clk);
            k++;
        end
        check("done_timeout", {31'b0, ndone >= target}, 1);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, g0, d0, l0;
        reset_n = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        a0 = 8'd5; b0 = 8'd3; a1 = 8'd7; b1 = 8'd2;
        #12;
        check("rst_gnt0", {31'b0, gnt0}, 0);
        check("rst_gnt1", {31'b0, gnt1}, 0);
        check("rst_done0", {31'b0, done0}, 0);
        check("rst_done1", {31'b0, done1}, 0);
        check("rst_q0", {24'b0, q0}, 0);
        check("rst_q1", {24'b0, q1}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_jobs", {16'b0, jobs}, 0);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        base = ndone; g0 = g0cnt;
        issue(0, 8'd48, 8'd18);
        wait_done(base + 1);
        check("t1_q0", {24'b0, q0}, 6);
        check("t1_jobs", {16'b0, jobs}, 1);
        check("t1_q1", {24'b0, q1}, 0);
        check("t1_gnt0_pulses", g0cnt - g0, 1);

        do_reset();
        base = ndone;
        fork
            issue(0, 8'd12, 8'd8);
            issue(1, 8'd35, 8'd21);
        join
        wait_done(base + 2);
        check("t2_order0", gq.size() > 0 ? gq[0] : 9, 0);
        check("t2_order1", gq.size() > 1 ? gq[1] : 9, 1);
        check("t2_q0", {24'b0, q0}, 4);
        check("t2_q1", {24'b0, q1}, 7);
        check("t2_jobs", {16'b0, jobs}, 2);

        gq.delete();
        base = ndone;
        fork
            drive(0, 3, 1'b1);
            drive(1, 3, 1'b1);
        join
        wait_done(base + 6);
        check("t3_grants", gq.size(), 6);
        for (int i = 1; i < gq.size(); i++)
            check("t3_alternate", {31'b0, gq[i] != gq[i-1]}, 1);

        issue(0, 8'd255, 8'd1);
        repeat (10) @(posedge clk);
        #1;
        check("t4_busy_mid", {31'b0, busy}, 1);
        reset_n = 1'b0;
        #1;
        check("t4_rst_busy", {31'b0, busy}, 0);
        check("t4_rst_jobs", {16'b0, jobs}, 0);
        check("t4_rst_q0", {24'b0, q0}, 0);
        check("t4_rst_q1", {24'b0, q1}, 0);
        check("t4_rst_done0", {31'b0, done0}, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        d0 = ndone;
        repeat (300) @(posedge clk);
        #1;
        check("t4_no_done", ndone, d0);
        check("t4_jobs", {16'b0, jobs}, 0);
        issue(0, 8'd9, 8'd6);
        wait_done(d0 + 1);
        check("t4_q0", {24'b0, q0}, 3);

        base = ndone; l0 = ld_cnt;
        issue(1, 8'd0, 8'd9);
        wait_done(base + 1);
        check("t5_q1", {24'b0, q1}, 9);
`ifdef GCD_SCHED_ZERO_BYPASS_EN
        check("t5_latency", done_cyc - gnt_cyc, 2);
        check("t5_ld_count", ld_cnt - l0, 0);
`else
        check("t5_ld_count", ld_cnt - l0, 1);
`endif

        base = ndone;
        fork
            drive(0, 8, 1'b0);
            drive(1, 8, 1'b0);
        join
        wait_done(base + 16);

        base = ndone;
        force dut.jobs = 16'hffff;
        mjobs = 16'hffff;
        @(posedge clk);
        #1;
        release dut.jobs;
        issue(0, 8'd21, 8'd14);
        wait_done(base + 1);
        check("t6_wrap_jobs", {16'b0, jobs}, 0);
        check("t6_q0", {24'b0, q0}, 7);

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
